// File: rtl/exc_redirect_ctrl_if.sv
// Request/redirect bundle between the ID stage, hazard unit and the exception sequencer.
// Pure wiring, no latency; the ID stall of the hazard unit holds requests while busy is high.
interface exc_redirect_ctrl_if #(
  parameter int PC_W = 16
);
  logic            siic;
  logic            rti;
  logic [PC_W-1:0] pc_ID;
  logic            busy;
  logic            idex_bubble;
  logic            flush_IFID;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;
  logic [PC_W-1:0] epc;
  logic            in_handler;

  modport master (
    output siic, rti, pc_ID,
    input  busy, idex_bubble, flush_IFID, pc_load, pc_target, epc, in_handler
  );

  modport slave (
    input  siic, rti, pc_ID,
    output busy, idex_bubble, flush_IFID, pc_load, pc_target, epc, in_handler
  );
endinterface

// File: rtl/exc_redirect_ctrl.sv
// Drains older instructions on siic/rti, then redirects fetch to the handler vector or saved EPC.
// Latency: request seen in IDLE at cycle N gives pc_load in cycle N+1+DRAIN_CYCLES.
// Backpressure: requests are ignored while busy; the hazard unit keeps the instruction stalled in ID.
module exc_redirect_ctrl #(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] VECTOR       = 16'h0002,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  exc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

  state_t          state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic            op, op_nxt;          // 0 = siic, 1 = rti
  logic [PC_W-1:0] epc_q, epc_nxt;
  logic            inh_q, inh_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      op    <= 1'b0;
      epc_q <= '0;
      inh_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
      epc_q <= epc_nxt;
      inh_q <= inh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op;
    epc_nxt   = epc_q;
    inh_nxt   = inh_q;
    case (state)
      IDLE: begin
        // siic wins when both arrive together; epc is only captured on siic entry
        if (bus.siic) begin
          op_nxt    = 1'b0;
          epc_nxt   = bus.pc_ID + PC_W'(1);
          cnt_nxt   = CNT_INIT;
          state_nxt = DRAIN;
        end else if (bus.rti) begin
          op_nxt    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == 3'd0) state_nxt = REDIRECT;
        else             cnt_nxt   = cnt - 3'd1;
      end
      REDIRECT: begin
        inh_nxt   = ~op;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = (state != IDLE);
  // Combinational so the siic/rti instruction itself is replaced by a NOP on entry to EX
  assign bus.idex_bubble = (state != IDLE) | (bus.siic | bus.rti);
  assign bus.flush_IFID  = (state == REDIRECT);
  assign bus.pc_load     = (state == REDIRECT);
  assign bus.pc_target   = (state == REDIRECT) ? (op ? epc_q : VECTOR) : '0;
  assign bus.epc         = epc_q;
  assign bus.in_handler  = inh_q;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Cycle-by-cycle vector table for exc_redirect_ctrl plus a latency/pulse-count sequence.
module tb_exc_redirect_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exc_redirect_ctrl_if #(.PC_W(16)) bus ();

  exc_redirect_ctrl #(.PC_W(16), .VECTOR(16'h0002), .DRAIN_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        siic;
    logic        rti;
    logic [15:0] pc;
    logic        busy;
    logic        bub;
    logic        fl;
    logic        ld;
    logic [15:0] tgt;
    logic [15:0] epc;
    logic        inh;
  } vec_t;

  vec_t tv[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic r, s, t, input logic [15:0] pc,
                              input logic b, bu, f, l, input logic [15:0] tg, ep, input logic ih);
    vec_t v;
    v.rst = r; v.siic = s; v.rti = t; v.pc = pc;
    v.busy = b; v.bub = bu; v.fl = f; v.ld = l; v.tgt = tg; v.epc = ep; v.inh = ih;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    int lat;
    int pulses;

    // Each record: inputs for one cycle and the outputs expected in that same cycle
    //            rst siic rti pc        busy bub fl ld tgt       epc       inh
    // reset state
    tv.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));
    // basic siic at pc 0x0010
    tv.push_back(mk(0, 1, 0, 16'h0010, 0, 1, 0, 0, 16'h0000, 16'h0000, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 16'h0010, 1, 1, 0, 0, 16'h0000, 16'h0011, 0));
    tv.push_back(mk(0, 0, 0, 16'h0010, 1, 1, 1, 1, 16'h0002, 16'h0011, 0));
    tv.push_back(mk(0, 0, 0, 16'h0010, 0, 0, 0, 0, 16'h0000, 16'h0011, 1));
    // rti return
    tv.push_back(mk(0, 0, 1, 16'h0040, 0, 1, 0, 0, 16'h0000, 16'h0011, 1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 16'h0040, 1, 1, 0, 0, 16'h0000, 16'h0011, 1));
    tv.push_back(mk(0, 0, 0, 16'h0040, 1, 1, 1, 1, 16'h0011, 16'h0011, 1));
    tv.push_back(mk(0, 0, 0, 16'h0040, 0, 0, 0, 0, 16'h0000, 16'h0011, 0));
    // simultaneous siic and rti
    tv.push_back(mk(0, 1, 1, 16'h0100, 0, 1, 0, 0, 16'h0000, 16'h0011, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 16'h0100, 1, 1, 0, 0, 16'h0000, 16'h0101, 0));
    tv.push_back(mk(0, 0, 0, 16'h0100, 1, 1, 1, 1, 16'h0002, 16'h0101, 0));
    tv.push_back(mk(0, 0, 0, 16'h0100, 0, 0, 0, 0, 16'h0000, 16'h0101, 1));
    // held siic while stalled, pc_ID changing during DRAIN
    tv.push_back(mk(0, 1, 0, 16'h0010, 0, 1, 0, 0, 16'h0000, 16'h0101, 1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 1, 0, 16'h0200, 1, 1, 0, 0, 16'h0000, 16'h0011, 1));
    tv.push_back(mk(0, 1, 0, 16'h0200, 1, 1, 1, 1, 16'h0002, 16'h0011, 1));
    tv.push_back(mk(0, 0, 0, 16'h0200, 0, 0, 0, 0, 16'h0000, 16'h0011, 1));
    tv.push_back(mk(0, 0, 0, 16'h0200, 0, 0, 0, 0, 16'h0000, 16'h0011, 1));
    // back-to-back: rti in the cycle right after REDIRECT
    tv.push_back(mk(0, 1, 0, 16'h0030, 0, 1, 0, 0, 16'h0000, 16'h0011, 1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 16'h0030, 1, 1, 0, 0, 16'h0000, 16'h0031, 1));
    tv.push_back(mk(0, 0, 0, 16'h0030, 1, 1, 1, 1, 16'h0002, 16'h0031, 1));
    tv.push_back(mk(0, 0, 1, 16'h0030, 0, 1, 0, 0, 16'h0000, 16'h0031, 1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 16'h0030, 1, 1, 0, 0, 16'h0000, 16'h0031, 1));
    tv.push_back(mk(0, 0, 0, 16'h0030, 1, 1, 1, 1, 16'h0031, 16'h0031, 1));
    tv.push_back(mk(0, 0, 0, 16'h0030, 0, 0, 0, 0, 16'h0000, 16'h0031, 0));
    // epc wrap
    tv.push_back(mk(0, 1, 0, 16'hFFFF, 0, 1, 0, 0, 16'h0000, 16'h0031, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 16'hFFFF, 1, 1, 0, 0, 16'h0000, 16'h0000, 0));
    tv.push_back(mk(0, 0, 0, 16'hFFFF, 1, 1, 1, 1, 16'h0002, 16'h0000, 0));
    tv.push_back(mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 16'h0000, 1));
    // reset during DRAIN aborts the redirect
    tv.push_back(mk(0, 1, 0, 16'h0500, 0, 1, 0, 0, 16'h0000, 16'h0000, 1));
    tv.push_back(mk(0, 0, 0, 16'h0500, 1, 1, 0, 0, 16'h0000, 16'h0501, 1));
    tv.push_back(mk(1, 0, 0, 16'h0500, 1, 1, 0, 0, 16'h0000, 16'h0501, 1));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 0, 0, 16'h0500, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));
    // rti outside a handler returns to epc (0 after reset)
    tv.push_back(mk(0, 0, 1, 16'h0600, 0, 1, 0, 0, 16'h0000, 16'h0000, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 16'h0600, 1, 1, 0, 0, 16'h0000, 16'h0000, 0));
    tv.push_back(mk(0, 0, 0, 16'h0600, 1, 1, 1, 1, 16'h0000, 16'h0000, 0));
    tv.push_back(mk(0, 0, 0, 16'h0600, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));

    rst = 1'b1;
    bus.siic = 1'b0;
    bus.rti = 1'b0;
    bus.pc_ID = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #1;
      rst = tv[i].rst;
      bus.siic = tv[i].siic;
      bus.rti = tv[i].rti;
      bus.pc_ID = tv[i].pc;
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_idex_bubble", i), 32'(bus.idex_bubble), 32'(tv[i].bub));
      chk($sformatf("v%0d_flush_IFID", i), 32'(bus.flush_IFID), 32'(tv[i].fl));
      chk($sformatf("v%0d_pc_load", i), 32'(bus.pc_load), 32'(tv[i].ld));
      chk($sformatf("v%0d_pc_target", i), 32'(bus.pc_target), 32'(tv[i].tgt));
      chk($sformatf("v%0d_epc", i), 32'(bus.epc), 32'(tv[i].epc));
      chk($sformatf("v%0d_in_handler", i), 32'(bus.in_handler), 32'(tv[i].inh));
    end

    // Latency and single-pulse check: one-cycle siic, then watch a bounded window
    lat = -1;
    pulses = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.siic = 1'b1;
    bus.rti = 1'b0;
    bus.pc_ID = 16'h0700;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.pc_load) begin
        pulses++;
        if (lat < 0) lat = c;
      end
      @(posedge clk);
      #1;
      bus.siic = 1'b0;
    end
    @(negedge clk);
    chk("seq_latency", 32'(lat), 32'd4);
    chk("seq_pulses", 32'(pulses), 32'd1);
    chk("seq_epc", 32'(bus.epc), 32'h0701);
    chk("seq_in_handler", 32'(bus.in_handler), 32'd1);
    chk("seq_idle", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
